// File: rtl/run_checker.sv
// End-of-run checker: snoops CPU register-file/data-memory writes, detects halt or timeout,
// then compares every loaded slot in order. Optional trace output: RUN_CHECKER_TRACE_EN.
module run_checker #(
    parameter int NUM_CHECKS  = 4,
    parameter int TIMEOUT     = 1000,
    parameter int HALT_STABLE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        chk_valid,
    output logic        chk_ready,
    input  logic        chk_kind,
    input  logic [31:0] chk_addr,
    input  logic [31:0] chk_value,
    input  logic [31:0] pc,
    input  logic        rf_we,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_waddr,
    input  logic [31:0] dm_wdata,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_index,
    output logic [31:0] cycle_count
);

    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_kind [NUM_CHECKS];
    logic [31:0] r_addr [NUM_CHECKS];
    logic [31:0] r_exp  [NUM_CHECKS];
    logic [31:0] r_obs  [NUM_CHECKS];

    logic [4:0]  r_count;
    logic [4:0]  r_check_idx;
    logic [31:0] r_prev_pc;
    logic [31:0] r_stable_cnt;
    logic [31:0] r_cycle_count;
    logic        r_pass;
    logic [4:0]  r_fail_index;
    logic        r_failed;

    logic                  w_load_fire;
    logic                  w_halt;
    logic                  w_timeout;
    logic [IDX_W-1:0]      w_check_slot;
    logic                  w_mismatch;
    logic                  w_check_last;
    logic                  w_check_pass;
    logic [NUM_CHECKS-1:0] w_rf_hit;
    logic [NUM_CHECKS-1:0] w_dm_hit;

    assign w_load_fire  = chk_valid & chk_ready;
    assign w_halt       = (pc == r_prev_pc) && (r_stable_cnt + 32'd1 == 32'(HALT_STABLE));
    assign w_timeout    = (r_cycle_count + 32'd1 == 32'(TIMEOUT));
    assign w_check_slot = r_check_idx[IDX_W-1:0];
    assign w_mismatch   = (r_count != 5'd0) && (r_exp[w_check_slot] != r_obs[w_check_slot]);
    assign w_check_last = (r_count == 5'd0) || (r_check_idx == r_count - 5'd1);
    assign w_check_pass = !(r_failed || w_mismatch);

    // Register x0 is never a real write target, so it can never hit a register slot.
    always_comb begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
            w_rf_hit[i] = !r_kind[i] && rf_we && (rf_waddr != 5'd0) && (r_addr[i][4:0] == rf_waddr);
            w_dm_hit[i] = r_kind[i] && dm_we && (r_addr[i] == dm_waddr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_timeout) w_next_state = S_DONE;
                     else if (w_halt) w_next_state = S_CHECK;
            S_CHECK: if (w_check_last) w_next_state = S_DONE;
            default: w_next_state = S_DONE;
        endcase
    end

    always_comb begin
        chk_ready = (r_state == S_LOAD) && (r_count < 5'(NUM_CHECKS));
        done      = (r_state == S_DONE);
    end

    assign pass        = r_pass;
    assign fail_index  = r_fail_index;
    assign cycle_count = r_cycle_count;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slot arrays are small flop banks that must read empty after reset, so they are cleared here.
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r_kind[i] <= 1'b0;
                r_addr[i] <= '0;
                r_exp[i]  <= '0;
                r_obs[i]  <= '0;
            end
            r_count       <= '0;
            r_check_idx   <= '0;
            r_prev_pc     <= '0;
            r_stable_cnt  <= '0;
            r_cycle_count <= '0;
            r_pass        <= 1'b0;
            r_fail_index  <= '0;
            r_failed      <= 1'b0;
        end else begin
            r_prev_pc <= pc;
            case (r_state)
                S_LOAD: begin
                    r_stable_cnt <= '0;
                    if (w_load_fire) begin
                        r_kind[r_count[IDX_W-1:0]] <= chk_kind;
                        r_addr[r_count[IDX_W-1:0]] <= chk_addr;
                        r_exp[r_count[IDX_W-1:0]]  <= chk_value;
                        r_obs[r_count[IDX_W-1:0]]  <= '0;
                        r_count <= r_count + 5'd1;
                    end
                end
                S_RUN: begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                    r_stable_cnt  <= (pc != r_prev_pc) ? '0 : r_stable_cnt + 32'd1;
                    for (int i = 0; i < NUM_CHECKS; i++) begin
                        if (w_rf_hit[i]) r_obs[i] <= rf_wdata;
                        if (w_dm_hit[i]) r_obs[i] <= dm_wdata;
                    end
                    if (w_timeout) begin
                        r_pass       <= 1'b0;
                        r_fail_index <= 5'(NUM_CHECKS);
                    end
                end
                S_CHECK: begin
                    r_check_idx <= r_check_idx + 5'd1;
                    if (w_mismatch && !r_failed) begin
                        r_failed     <= 1'b1;
                        r_fail_index <= r_check_idx;
                    end
                    if (w_check_last) r_pass <= w_check_pass;
                end
                default: ;
            endcase
        end
    end

`ifdef RUN_CHECKER_TRACE_EN
    always @(posedge clk) begin
        if (!reset && r_state == S_RUN) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (w_rf_hit[i]) $display("%0t run_checker: slot %0d <= %h (reg)", $time, i, rf_wdata);
                if (w_dm_hit[i]) $display("%0t run_checker: slot %0d <= %h (mem)", $time, i, dm_wdata);
            end
        end
        if (!reset && r_state == S_CHECK && r_count != 5'd0)
            $display("%0t run_checker: slot %0d expected %h observed %h", $time, r_check_idx,
                     r_exp[w_check_slot], r_obs[w_check_slot]);
        if (!reset && r_state != S_DONE && w_next_state == S_DONE)
            $display("%0t run_checker: %s cycle_count=%0d", $time,
                     (r_state == S_CHECK && w_check_pass) ? "PASS" : "FAIL",
                     (r_state == S_RUN) ? r_cycle_count + 32'd1 : r_cycle_count);
    end
`else
    // Silent build: no simulation output, identical logic.
`endif

endmodule

// File: tb/tb_run_checker.sv
// Self-checking bench for run_checker: directed and random programs scored by a trace-level model.
module tb_run_checker;

    localparam int NC     = 4;
    localparam int TO     = 50;
    localparam int HS     = 8;
    localparam int MAXC   = 80;
    localparam int BUDGET = 75;

    logic        clk = 1'b0;
    logic        reset, start, chk_valid, chk_ready, chk_kind;
    logic [31:0] chk_addr, chk_value, pc;
    logic        rf_we, dm_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, dm_waddr, dm_wdata;
    logic        done, pass;
    logic [4:0]  fail_index;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    run_checker #(.NUM_CHECKS(NC), .TIMEOUT(TO), .HALT_STABLE(HS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_kind(chk_kind),
        .chk_addr(chk_addr), .chk_value(chk_value), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata),
        .done(done), .pass(pass), .fail_index(fail_index), .cycle_count(cycle_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Program description: load beats plus a per-RUN-cycle trace of CPU activity.
    int          n_beats;
    logic        b_kind [8];
    logic [31:0] b_addr [8];
    logic [31:0] b_exp  [8];
    logic [31:0] load_pc;
    logic [31:0] t_pc [MAXC];
    logic        t_rf_we [MAXC];
    logic [4:0]  t_rf_waddr [MAXC];
    logic [31:0] t_rf_wdata [MAXC];
    logic        t_dm_we [MAXC];
    logic [31:0] t_dm_waddr [MAXC];
    logic [31:0] t_dm_wdata [MAXC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_program();
        n_beats = 0;
        load_pc = 32'h0;
        for (int t = 0; t < MAXC; t++) begin
            t_pc[t] = 32'h0;
            t_rf_we[t] = 1'b0; t_rf_waddr[t] = 5'd0; t_rf_wdata[t] = 32'h0;
            t_dm_we[t] = 1'b0; t_dm_waddr[t] = 32'h0; t_dm_wdata[t] = 32'h0;
        end
    endtask

    task automatic add_beat(input logic kind, input logic [31:0] addr, input logic [31:0] exp);
        b_kind[n_beats] = kind;
        b_addr[n_beats] = addr;
        b_exp[n_beats]  = exp;
        n_beats++;
    endtask

    // PC walks forward until spin_start, then parks at a fixed spin address.
    task automatic set_spin(input int spin_start);
        for (int t = 0; t < MAXC; t++)
            t_pc[t] = (t < spin_start) ? 32'(4 * (t + 1)) : 32'h1000;
    endtask

    task automatic rf_write(input int t, input logic [4:0] a, input logic [31:0] d);
        t_rf_we[t] = 1'b1; t_rf_waddr[t] = a; t_rf_wdata[t] = d;
    endtask

    task automatic dm_write(input int t, input logic [31:0] a, input logic [31:0] d);
        t_dm_we[t] = 1'b1; t_dm_waddr[t] = a; t_dm_wdata[t] = d;
    endtask

    function automatic logic [31:0] pc_at(input int k);
        return (k < 0) ? load_pc : t_pc[k];
    endfunction

    // Last RUN cycle: first cycle t closing a window of HS+1 equal PCs, unless the timeout cycle comes first or ties.
    function automatic int model_end(output bit timed_out);
        for (int t = HS - 1; t < TO - 1; t++) begin
            bit same = 1'b1;
            for (int k = t - HS + 1; k <= t; k++)
                if (pc_at(k) != pc_at(t - HS)) same = 1'b0;
            if (same) begin
                timed_out = 1'b0;
                return t;
            end
        end
        timed_out = 1'b1;
        return TO - 1;
    endfunction

    task automatic drive(input int t);
        pc = t_pc[t];
        rf_we = t_rf_we[t]; rf_waddr = t_rf_waddr[t]; rf_wdata = t_rf_wdata[t];
        dm_we = t_dm_we[t]; dm_waddr = t_dm_waddr[t]; dm_wdata = t_dm_wdata[t];
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; chk_valid = 1'b0; chk_kind = 1'b0;
        chk_addr = '0; chk_value = '0; pc = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; dm_we = 1'b0; dm_waddr = '0; dm_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(chk_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fidx", 32'(fail_index), 32'd0);
        check("rst_cc", cycle_count, 32'd0);
    endtask

    task automatic load_and_run(input string name);
        bit          to;
        bit          pass_m;
        int          end_t, n_slots, edges, fidx;
        logic [31:0] o;
        logic [31:0] cc_done;
        pc = load_pc;
        for (int i = 0; i < n_beats; i++) begin
            chk_valid = 1'b1; chk_kind = b_kind[i]; chk_addr = b_addr[i]; chk_value = b_exp[i];
            check({name, "_ready"}, 32'(chk_ready), 32'(i < NC));
            tick();
        end
        chk_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_ready_run"}, 32'(chk_ready), 32'd0);

        n_slots = (n_beats < NC) ? n_beats : NC;
        end_t   = model_end(to);
        pass_m  = !to;
        fidx    = NC;
        for (int s = 0; s < n_slots; s++) begin
            o = 32'h0;
            for (int t = 0; t <= end_t; t++) begin
                if (!b_kind[s] && t_rf_we[t] && t_rf_waddr[t] != 5'd0 && t_rf_waddr[t] == b_addr[s][4:0])
                    o = t_rf_wdata[t];
                if (b_kind[s] && t_dm_we[t] && t_dm_waddr[t] == b_addr[s])
                    o = t_dm_wdata[t];
            end
            if (!to && pass_m && o != b_exp[s]) begin
                pass_m = 1'b0;
                fidx   = s;
            end
        end

        edges = 0;
        while (!done && edges < BUDGET) begin
            drive(edges);
            tick();
            edges++;
        end
        rf_we = 1'b0;
        dm_we = 1'b0;

        check({name, "_done"}, 32'(done), 32'd1);
        if (to || n_slots > 0)
            check({name, "_latency"}, 32'(edges), 32'(end_t + 1 + (to ? 0 : n_slots)));
        check({name, "_cc"}, cycle_count, 32'(end_t + 1));
        check({name, "_pass"}, 32'(pass), 32'(pass_m));
        if (!pass_m)
            check({name, "_fidx"}, 32'(fail_index), 32'(fidx));

        cc_done = cycle_count;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check({name, "_hold_done"}, 32'(done), 32'd1);
        check({name, "_hold_cc"}, cycle_count, cc_done);
    endtask

    task automatic gen_random();
        int spin;
        clear_program();
        n_beats = int'($urandom_range(1, NC));
        for (int i = 0; i < n_beats; i++) begin
            b_kind[i] = 1'($urandom_range(0, 1));
            b_addr[i] = b_kind[i] ? 32'h100 + 32'(4 * $urandom_range(0, 2))
                                  : {27'($urandom), 5'($urandom_range(0, 3))};
            b_exp[i]  = 32'($urandom_range(0, 3));
        end
        spin = int'($urandom_range(0, 48));
        for (int t = 0; t < MAXC; t++) begin
            if (t >= spin)                              t_pc[t] = 32'h1000;
            else if (t > 0 && $urandom_range(0, 3) == 0) t_pc[t] = t_pc[t - 1];
            else                                        t_pc[t] = 32'(4 * (t + 1));
            if ($urandom_range(0, 1) == 1) rf_write(t, 5'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) dm_write(t, 32'h100 + 32'(4 * $urandom_range(0, 2)), 32'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        // Accumulation program: r2 sums 1..9, the total is stored at mem 3, then the CPU spins.
        clear_program();
        add_beat(1'b0, 32'd2, 32'd45);
        add_beat(1'b1, 32'd3, 32'd45);
        set_spin(10);
        for (int t = 0; t < 9; t++) rf_write(t, 5'd2, 32'((t + 1) * (t + 2) / 2));
        dm_write(9, 32'd3, 32'd45);
        reset_dut();
        load_and_run("accum");
        check("accum_pass_const", 32'(pass), 32'd1);
        check("accum_cc_const", cycle_count, 32'd19);

        // Wrong final value in the only slot.
        clear_program();
        add_beat(1'b0, 32'd2, 32'd45);
        set_spin(4);
        rf_write(1, 5'd2, 32'd44);
        reset_dut();
        load_and_run("wrong");
        check("wrong_fidx_const", 32'(fail_index), 32'd0);

        // Only slot 1 mismatches, then slots 1 and 2 both mismatch: first failure stays latched.
        for (int v = 0; v < 2; v++) begin
            clear_program();
            add_beat(1'b0, 32'd5, 32'd1);
            add_beat(1'b0, 32'd6, 32'd7);
            add_beat(1'b1, 32'd8, 32'hdeadbeef);
            set_spin(3);
            rf_write(0, 5'd5, 32'd1);
            rf_write(1, 5'd6, 32'd8);
            dm_write(2, 32'd8, (v == 0) ? 32'hdeadbeef : 32'hdeadbee0);
            reset_dut();
            load_and_run((v == 0) ? "first_fail" : "two_fails");
            check("fidx_latched_const", 32'(fail_index), 32'd1);
        end

        // PC never stable: forced fail after exactly TO RUN cycles.
        clear_program();
        add_beat(1'b0, 32'd1, 32'd0);
        set_spin(MAXC);
        reset_dut();
        load_and_run("timeout");
        check("timeout_cc_const", cycle_count, 32'd50);
        check("timeout_fidx_const", 32'(fail_index), 32'd4);

        // Halt completes on the same edge as the timeout: timeout must win.
        clear_program();
        add_beat(1'b0, 32'd1, 32'd0);
        set_spin(41);
        reset_dut();
        load_and_run("tie");
        check("tie_pass_const", 32'(pass), 32'd0);
        check("tie_fidx_const", 32'(fail_index), 32'd4);

        // Fifth beat refused; x0 write ignored while a same-cycle memory write lands; CHECK-phase writes ignored.
        clear_program();
        add_beat(1'b0, 32'd0, 32'd0);
        add_beat(1'b1, 32'h20, 32'h55);
        add_beat(1'b0, 32'd7, 32'd9);
        add_beat(1'b1, 32'h24, 32'd1);
        add_beat(1'b0, 32'd7, 32'h99);
        set_spin(3);
        rf_write(0, 5'd0, 32'h77);
        dm_write(0, 32'h20, 32'h55);
        rf_write(1, 5'd7, 32'd9);
        dm_write(2, 32'h24, 32'd1);
        for (int t = 12; t < 15; t++) rf_write(t, 5'd7, 32'hbad);
        reset_dut();
        load_and_run("full");
        check("full_pass_const", 32'(pass), 32'd1);

        // Reset during RUN abandons the run and empties every slot.
        clear_program();
        add_beat(1'b0, 32'd3, 32'd3);
        add_beat(1'b0, 32'd4, 32'd4);
        add_beat(1'b1, 32'h40, 32'd4);
        reset_dut();
        for (int i = 0; i < n_beats; i++) begin
            chk_valid = 1'b1; chk_kind = b_kind[i]; chk_addr = b_addr[i]; chk_value = b_exp[i];
            tick();
        end
        chk_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 5; t++) begin
            pc = 32'(4 * (t + 1));
            tick();
        end
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(chk_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cc", cycle_count, 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        reset = 1'b0;
        clear_program();
        for (int i = 0; i < NC; i++) add_beat(1'b0, 32'(i + 1), 32'd0);
        set_spin(2);
        load_and_run("after_rst");

        // Zero slots loaded: halt still produces a passing result.
        clear_program();
        set_spin(0);
        reset_dut();
        load_and_run("empty");
        check("empty_pass_const", 32'(pass), 32'd1);

        for (int r = 0; r < 8; r++) begin
            gen_random();
            reset_dut();
            load_and_run($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
